// File: rtl/freq_input_pkg.sv
// Shared defaults and helpers for the frequency input conditioner.
// Imported by the per-channel conditioner and the top-level wrapper.
package freq_input_pkg;

   localparam int SYNC_STAGES_DEF    = 2;
   localparam int FILTER_LEN_DEF     = 3;
   localparam int TIMEOUT_CYCLES_DEF = 65535;

   // Bits needed to hold a counter value from 0 up to and including max_val.
   function automatic int cnt_width(input int max_val);
      if (max_val < 1) return 1;
      return $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/freq_input_channel.sv
// One conditioned frequency input: synchronizer, deglitch filter,
// rising-edge pulse and loss-of-signal flag.
module freq_input_channel
   import freq_input_pkg::*;
#(
   parameter int SYNC_STAGES    = SYNC_STAGES_DEF,
   parameter int FILTER_LEN     = FILTER_LEN_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic enable_i,
   input  logic f_in,
   output logic f_out,
   output logic rise_o,
   output logic lost_o
);

   localparam int FCW = cnt_width(FILTER_LEN);
   localparam int TCW = cnt_width(TIMEOUT_CYCLES);
   localparam logic [FCW-1:0] F_LAST = FCW'(FILTER_LEN - 1);
   localparam logic [TCW-1:0] T_MAX  = TCW'(TIMEOUT_CYCLES);

   if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
      $error("freq_input_channel: SYNC_STAGES must be within 2..4");
   end
   if (FILTER_LEN < 1 || FILTER_LEN > 15) begin : g_bad_filter
      $error("freq_input_channel: FILTER_LEN must be within 1..15");
   end
   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("freq_input_channel: TIMEOUT_CYCLES must be at least 2");
   end

   logic [SYNC_STAGES-1:0] sync_q;
   logic [FCW-1:0]         fcnt_q;
   logic [TCW-1:0]         tcnt_q;
   logic                   f_out_q;
   logic                   rise_q;

   logic sync;
   logic disagree;
   logic commit;
   logic rise_next;

   assign sync      = sync_q[SYNC_STAGES-1];
   assign disagree  = (sync != f_out_q);
   assign commit    = disagree && (fcnt_q == F_LAST);
   assign rise_next = commit && sync;

   // Plain flop chain; keeps sampling even while the channel is disabled.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], f_in};
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         fcnt_q  <= '0;
         f_out_q <= 1'b0;
         rise_q  <= 1'b0;
      end else if (!enable_i) begin
         fcnt_q  <= '0;
         f_out_q <= 1'b0;
         rise_q  <= 1'b0;
      end else begin
         rise_q <= rise_next;
         if (!disagree) begin
            fcnt_q <= '0;
         end else if (commit) begin
            f_out_q <= sync;
            fcnt_q  <= '0;
         end else begin
            fcnt_q <= fcnt_q + 1'b1;
         end
      end
   end

   // A rise restarts the timeout on the same edge, so it wins over saturation.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         tcnt_q <= '0;
      end else if (!enable_i) begin
         tcnt_q <= '0;
      end else if (rise_next) begin
         tcnt_q <= '0;
      end else if (tcnt_q != T_MAX) begin
         tcnt_q <= tcnt_q + 1'b1;
      end
   end

   assign f_out  = f_out_q;
   assign rise_o = rise_q;
   assign lost_o = (tcnt_q == T_MAX);

endmodule

// File: rtl/freq_input_conditioner.sv
// Conditions the raw frequency inputs ahead of the freqmeters F_in bus;
// every channel is an independent freq_input_channel.
module freq_input_conditioner
   import freq_input_pkg::*;
#(
   parameter int INPUTS_COUNT   = 24,
   parameter int SYNC_STAGES    = SYNC_STAGES_DEF,
   parameter int FILTER_LEN     = FILTER_LEN_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [INPUTS_COUNT-1:0] enable_i,
   input  logic [INPUTS_COUNT-1:0] F_in,
   output logic [INPUTS_COUNT-1:0] F_out,
   output logic [INPUTS_COUNT-1:0] rise_o,
   output logic [INPUTS_COUNT-1:0] lost_o
);

   for (genvar c = 0; c < INPUTS_COUNT; c++) begin : g_ch
      freq_input_channel #(
         .SYNC_STAGES    (SYNC_STAGES),
         .FILTER_LEN     (FILTER_LEN),
         .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
      ) u_ch (
         .clk_i    (clk_i),
         .rst_i    (rst_i),
         .enable_i (enable_i[c]),
         .f_in     (F_in[c]),
         .f_out    (F_out[c]),
         .rise_o   (rise_o[c]),
         .lost_o   (lost_o[c])
      );
   end

endmodule
